// File: rtl/uart_frame_pkg.sv
// Shared types for the UART RX frame controller: FSM states,
// abort codes and the default start-of-frame marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CKSUM,
    S_DRAIN
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_TIMEOUT = 2'b00;
  localparam err_code_t ERR_LINE    = 2'b01;
  localparam err_code_t ERR_LEN     = 2'b10;
  localparam err_code_t ERR_CKSUM   = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic logic is_rx_state(state_e s);
    return (s == S_ADDR) || (s == S_LEN) ||
           (s == S_PAYLOAD) || (s == S_CKSUM);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8, synchronous write, asynchronous read.
// Storage is intentionally not reset.
module uart_frame_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic                       CLK,
  input  logic                       we_i,
  input  logic [$clog2(MAX_LEN)-1:0] waddr_i,
  input  logic [7:0]                 wdata_i,
  input  logic [$clog2(MAX_LEN)-1:0] raddr_i,
  output logic [7:0]                 rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART RX byte stream into checksummed register writes.
// Optional inter-byte timeout: define UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
  parameter int         TIMEOUT_TICKS = 160
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUD_X16_EN,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DATA_RDY,
  input  logic       PARITY_ERR,
  input  logic       FRM_ERR,
  output logic       WR_EN,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic       WR_RDY,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] ONE = IW'(1);

  state_e          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  err_code_t       code_q, code_d;
  logic            ferr_q, ferr_d;

  logic            buf_we;
  logic [7:0]      buf_rd;
  logic            rx_st;
  logic            byte_ok;
  logic            line_err;
  logic            len_bad;
  logic            drain;
  logic            xfer;
  logic            last;
  logic [7:0]      sum_add;
  logic [IW-1:0]   idx_inc;
  logic            timeout_hit;

  assign rx_st    = is_rx_state(state_q);
  assign byte_ok  = RX_DATA_RDY & ~(PARITY_ERR | FRM_ERR);
  assign line_err = RX_DATA_RDY & (PARITY_ERR | FRM_ERR);
  assign len_bad  = (RX_DATA == 8'd0) || (RX_DATA > 8'(MAX_LEN));
  assign drain    = (state_q == S_DRAIN);
  assign xfer     = drain & WR_RDY;
  assign last     = (idx_q == len_q - ONE);
  assign sum_add  = sum_q + RX_DATA;
  assign idx_inc  = idx_q + ONE;

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] to_q, to_d;

  // Silence on the line counts only while a frame is in flight.
  assign timeout_hit = rx_st & ~RX_DATA_RDY & BAUD_X16_EN &
                       (to_q == TO_LAST);

  always_comb begin
    to_d = to_q;
    if (!rx_st || RX_DATA_RDY || timeout_hit) begin
      to_d = '0;
    end else if (BAUD_X16_EN) begin
      to_d = to_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) to_q <= '0;
    else      to_q <= to_d;
  end
`else
  logic unused_baud;

  assign timeout_hit = 1'b0;
  assign unused_baud = BAUD_X16_EN ^ (TIMEOUT_TICKS == 0);
`endif

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .CLK     (CLK),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (RX_DATA),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rd)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      code_q  <= ERR_TIMEOUT;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      code_q  <= code_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    code_d  = code_q;
    ferr_d  = 1'b0;
    buf_we  = 1'b0;
    unique case (1'b1)
      rx_st && line_err: begin
        state_d = S_IDLE;
        ferr_d  = 1'b1;
        code_d  = ERR_LINE;
      end
      rx_st && timeout_hit: begin
        state_d = S_IDLE;
        ferr_d  = 1'b1;
        code_d  = ERR_TIMEOUT;
      end
      default: begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_ok && RX_DATA == SOF_BYTE) state_d = S_ADDR;
          end
          S_ADDR: begin
            if (byte_ok) begin
              addr_d  = RX_DATA;
              sum_d   = RX_DATA;
              state_d = S_LEN;
            end
          end
          S_LEN: begin
            if (byte_ok && len_bad) begin
              state_d = S_IDLE;
              ferr_d  = 1'b1;
              code_d  = ERR_LEN;
            end else if (byte_ok) begin
              len_d   = RX_DATA[IW-1:0];
              sum_d   = sum_add;
              idx_d   = '0;
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (byte_ok) begin
              buf_we = 1'b1;
              sum_d  = sum_add;
              idx_d  = idx_inc;
              if (idx_inc == len_q) state_d = S_CKSUM;
            end
          end
          S_CKSUM: begin
            if (byte_ok && sum_add == 8'd0) begin
              idx_d   = '0;
              state_d = S_DRAIN;
            end else if (byte_ok) begin
              state_d = S_IDLE;
              ferr_d  = 1'b1;
              code_d  = ERR_CKSUM;
            end
          end
          S_DRAIN: begin
            // Incoming bytes are dropped here; only WR_RDY moves us on.
            if (xfer && last) state_d = S_IDLE;
            else if (xfer)    idx_d   = idx_inc;
          end
          default: state_d = S_IDLE;
        endcase
      end
    endcase
  end

  always_comb begin
    WR_EN     = drain;
    WR_ADDR   = drain ? addr_q + 8'(idx_q) : 8'd0;
    WR_DATA   = drain ? buf_rd : 8'd0;
    FRAME_OK  = xfer & last;
    FRAME_ERR = ferr_q;
    ERR_CODE  = code_q;
    BUSY      = (state_q != S_IDLE);
  end

endmodule
